serial_operand_tx: RTL
======================

Name: serial_operand_tx

Overview:
Transmit side of the serial-adder link. Accepts two N-bit parallel operands through a valid/ready handshake. Clears the downstream serial adder, then streams both operands LSB-first, one bit pair per clock, onto the adder's `a` and `b` inputs. Flags the cycle where the adder's sum/carry are final, so a parallel operand source can drive the existing serial adder without hand-timed stimulus.

Parameters:
- N, default 4: operand width in bits; legal range 2..32.
- CLR_CYCLES, default 1: number of cycles the adder clear is held before a frame; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (low at a rising edge resets the block).
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- a_in  input  N  parallel operand A.
- b_in  input  N  parallel operand B.
- a  output  1  serial bit of A, LSB first, to adder `a`.
- b  output  1  serial bit of B, LSB first, to adder `b`.
- sa_clr  output  1  active-high clear to the serial adder's reset input.
- bit_valid  output  1  `a`/`b` carry a live bit this cycle.
- last  output  1  current bit pair is bit N-1 (MSB).
- busy  output  1  a frame is in progress (high in CLR, SHIFT and DONE).
- done  output  1  one-cycle pulse; the adder sum/carry are final this cycle.

Behaviour:
- All outputs are registered (driven directly from flops); there is no combinational input-to-output path.
- Reset state is IDLE. Reset output values: in_ready=1, sa_clr=1, a=0, b=0, bit_valid=0, last=0, busy=0, done=0. Shift registers and counters are cleared.
- FSM states: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - in_ready=1, sa_clr=1.
  - When in_valid and in_ready are both high at an edge, capture a_in/b_in into the shift registers and go to CLR.
  - a_in/b_in are ignored at every other time.
- CLR:
  - Held for exactly CLR_CYCLES cycles; sa_clr=1, in_ready=0, busy=1, a=b=0.
  - Then go to SHIFT.
- SHIFT:
  - Held for exactly N cycles; sa_clr=0, bit_valid=1.
  - In cycle k (k=0..N-1), a=A[k] and b=B[k]; shift right once per cycle.
  - last=1 only in cycle k=N-1.
  - Then go to DONE.
- DONE:
  - Held for 1 cycle; done=1, sa_clr=0, bit_valid=0, a=b=0.
  - The adder has absorbed all N bits, so its sum/carry outputs are valid for sampling this cycle.
  - Then go to IDLE.
- Latency: accept edge -> first bit after CLR_CYCLES cycles -> done pulse N+CLR_CYCLES+1 cycles after accept. A frame lasts N+CLR_CYCLES+1 cycles.
- Throughput: in_ready reasserts in the cycle after DONE, so the minimum accept-to-accept spacing is N+CLR_CYCLES+2 cycles.
- in_valid while busy: ignored, no capture. The source must hold in_valid until the handshake completes.
- Reset mid-frame: reset low at any edge aborts the frame. The next cycle is IDLE with reset output values; the in-flight operands are discarded and no done pulse is issued. Reset takes priority over a simultaneous handshake.
- Counter width: $clog2(N+1), and it never wraps within a frame. The CLR counter is 4 bits.

Decomposition:
- Package serial_tx_pkg holds:
  - the state enum (IDLE, CLR, SHIFT, DONE);
  - localparam DEFAULT_N = 4;
  - localparam DEFAULT_CLR_CYCLES = 1.
- Sub-module piso_shift (parameter N): load, shift_en, N-bit par_in, serial LSB out, synchronous active-low reset. It is instantiated twice, once for A and once for B.
- The FSM and counters live in the top level.

Test Plan:
1. N=4, a_in=4'b1111, b_in=4'b1010 -> a stream 1,1,1,1; b stream 0,1,0,1; last on the 4th bit; done at accept+6. The attached serial adder then shows sum=4'b1001, carry=1.
2. a_in=4'b1000, b_in=4'b0011 -> a stream 0,0,0,1; b stream 1,1,0,0; adder result sum=4'b1011, carry=0 at done.
3. in_valid held high with two successive operand pairs -> second accept exactly 7 cycles after the first; sa_clr high for at least 1 cycle before each frame; both adder results correct.
4. in_valid pulses with new operands during SHIFT -> ignored; the stream still carries the original operands; in_ready=0 throughout busy.
5. reset driven low at SHIFT bit 2 -> next cycle outputs are in_ready=1, sa_clr=1, bit_valid=0; no done pulse; the next frame is correct.
6. N=8, CLR_CYCLES=2, a_in=8'hFF, b_in=8'h01 -> sa_clr high for 2 cycles, then 8 bits; done at accept+11; adder sum=8'h00, carry=1.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial-adder transmit link.
//   state_t            : frame sequencer states
//   DEFAULT_N          : default operand width
//   DEFAULT_CLR_CYCLES : default adder-clear hold length
//   CLR_CNT_W          : width of the clear-phase counter
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_N          = 4;
  localparam int unsigned DEFAULT_CLR_CYCLES = 1;
  localparam int unsigned CLR_CNT_W          = 4;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, LSB first.
//   clk      : clock
//   reset    : synchronous active-low reset
//   load     : capture par_in (wins over shift_en)
//   shift_en : shift right by one
//   par_in   : parallel operand
//   ser_out  : current LSB of the register
module piso_shift
  import serial_tx_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] par_in,
  output logic         ser_out
);

  logic [N-1:0] sr;

  // Operand storage; zero is shifted into the MSB
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= par_in;
    end else if (shift_en) begin
      sr <= {1'b0, sr[N-1:1]};
    end
  end

  assign ser_out = sr[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Transmit side of the serial-adder link: accepts an operand pair over
// valid/ready, clears the downstream adder, streams both operands LSB first
// and pulses done when the adder result is final.
//   clk, reset          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a_in, b_in          : parallel operands
//   a, b                : serial bit pair to the adder
//   sa_clr              : adder clear (active high)
//   bit_valid, last     : live bit / MSB bit qualifiers
//   busy, done          : frame in progress / result-final pulse
module serial_operand_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned CLR_CYCLES = DEFAULT_CLR_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         a,
  output logic         b,
  output logic         sa_clr,
  output logic         bit_valid,
  output logic         last,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(N - 1);
  localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(CLR_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [CLR_CNT_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                   load;
  logic                   emit;
  logic                   a_ser, b_ser;

  piso_shift #(.N(N)) u_shift_a (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (emit),
    .par_in   (a_in),
    .ser_out  (a_ser)
  );

  piso_shift #(.N(N)) u_shift_b (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (emit),
    .par_in   (b_in),
    .ser_out  (b_ser)
  );

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic; emit marks an edge that presents a new bit pair
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    clr_cnt_nxt = clr_cnt;
    load        = 1'b0;
    emit        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load        = 1'b1;
          clr_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = CLR;
        end
      end
      CLR: begin
        if (clr_cnt == CLR_LAST) begin
          emit        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end else begin
          clr_cnt_nxt = clr_cnt + CLR_CNT_W'(1);
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          emit        = 1'b1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are flops decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready  <= 1'b1;
      sa_clr    <= 1'b1;
      a         <= 1'b0;
      b         <= 1'b0;
      bit_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      sa_clr    <= (state_nxt == IDLE) || (state_nxt == CLR);
      a         <= emit ? a_ser : 1'b0;
      b         <= emit ? b_ser : 1'b0;
      bit_valid <= (state_nxt == SHIFT);
      last      <= (state_nxt == SHIFT) && (bit_cnt_nxt == LAST_IDX);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

endmodule
